ysyx_23060221_lsu_axi: RTL and testbench

Parametrised load/store unit sitting between EXU and WBU, acting as a single-outstanding AXI4 master on the data bus.
- Successor to the fixed 32-bit LSU. Generalised bus width (32/64) and AXI ID width.
- Independent AW/W handshakes, registered load data.
- Misaligned-access detection and bus-error (xRESP) reporting toward WBU.

---
 rtl/ysyx_23060221_lsu_pkg.sv | 34 +++
 rtl/ysyx_23060221_lsu_lane.sv | 52 +++++
 rtl/ysyx_23060221_lsu_axi.sv | 228 ++++++++++++++++++++++
 tb/tb_ysyx_23060221_lsu_axi.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060221_lsu_pkg.sv
`default_nettype none
// ===========================================================================
// ysyx_23060221_lsu_pkg : shared encodings for the AXI load/store unit
// Revision: 1.0
// ===========================================================================
package ysyx_23060221_lsu_pkg;

    // memop[1:0] encodes access size; memop[2] selects zero-extension.
    localparam logic [2:0] MEMOP_NONE = 3'b111;
    localparam logic [1:0] SIZE_B     = 2'b00;
    localparam logic [1:0] SIZE_H     = 2'b01;
    localparam logic [1:0] SIZE_W     = 2'b10;

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_FAULT    = 2'b10;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR_R = 3'd1,
        S_DATA_R = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP_B = 3'd4,
        S_DONE   = 3'd5
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060221_lsu_lane.sv
`default_nettype none
// ===========================================================================
// ysyx_23060221_lsu_lane : byte-lane steering for stores, extraction/extension for loads
// Revision: 1.0
// ===========================================================================
module ysyx_23060221_lsu_lane
    import ysyx_23060221_lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  logic [2:0]                  memop_i,
    input  logic [31:0]                 wdata_i,
    input  logic [DATA_W-1:0]           rdata_i,
    output logic [DATA_W-1:0]           wdata_o,
    output logic [DATA_W/8-1:0]         wstrb_o,
    output logic [31:0]                 rdata_o
);

    localparam int STRB_W = DATA_W / 8;

    logic [$clog2(DATA_W)-1:0] w_shamt;
    logic [DATA_W-1:0]         w_shifted;
    logic [STRB_W-1:0]         w_base;
    logic                      w_sign;

    assign w_shamt   = {off_i, 3'b000};
    assign wdata_o   = DATA_W'(wdata_i) << w_shamt;
    assign wstrb_o   = w_base << off_i;
    assign w_shifted = rdata_i >> w_shamt;
    assign w_sign    = ~memop_i[2];

    always_comb begin
        w_base = '0;
        case (memop_i[1:0])
            SIZE_B:  w_base = STRB_W'(4'b0001);
            SIZE_H:  w_base = STRB_W'(4'b0011);
            default: w_base = STRB_W'(4'b1111);
        endcase
    end

    always_comb begin
        rdata_o = '0;
        case (memop_i[1:0])
            SIZE_B:  rdata_o = {{24{w_sign & w_shifted[7]}},  w_shifted[7:0]};
            SIZE_H:  rdata_o = {{16{w_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: rdata_o = w_shifted[31:0];
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060221_lsu_axi.sv
`default_nettype none
// ===========================================================================
// ysyx_23060221_lsu_axi : single-outstanding AXI4 master load/store unit
// Revision: 1.0
// ===========================================================================
module ysyx_23060221_lsu_axi
    import ysyx_23060221_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ID_W   = 4,
    parameter int LSU_ID = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_addr,
    input  logic [31:0]         in_wdata,
    input  logic [2:0]          in_memop,
    input  logic                in_memwr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_rdata,
    output logic                out_exc,
    output logic [1:0]          out_cause,
    output logic                awvalid,
    input  logic                awready,
    output logic [31:0]         awaddr,
    output logic [ID_W-1:0]     awid,
    output logic [7:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                wvalid,
    input  logic                wready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    input  logic [ID_W-1:0]     bid,
    output logic                arvalid,
    input  logic                arready,
    output logic [31:0]         araddr,
    output logic [ID_W-1:0]     arid,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    input  logic                rvalid,
    output logic                rready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic [ID_W-1:0]     rid
);

    localparam int OFF_W = $clog2(DATA_W / 8);

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  memop_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        bready_q;
    logic        out_valid_q;
    logic [31:0] out_rdata_q;
    logic        out_exc_q;
    logic [1:0]  out_cause_q;

    logic        w_aw_fire;
    logic        w_w_fire;
    logic [31:0] w_load;
    logic        w_unused_ok;

    // Single outstanding transaction: response IDs and low resp bits carry no information here.
    assign w_unused_ok = ^{bid, rid, bresp[0], rresp[0]};

    ysyx_23060221_lsu_lane #(
        .DATA_W (DATA_W)
    ) u_lane (
        .off_i   (addr_q[OFF_W-1:0]),
        .memop_i (memop_q),
        .wdata_i (wdata_q),
        .rdata_i (rdata),
        .wdata_o (wdata),
        .wstrb_o (wstrb),
        .rdata_o (w_load)
    );

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_rdata = out_rdata_q;
    assign out_exc   = out_exc_q;
    assign out_cause = out_cause_q;

    assign arvalid = arvalid_q;
    assign araddr  = addr_q;
    assign arid    = ID_W'(LSU_ID);
    assign arlen   = 8'd0;
    assign arsize  = {1'b0, memop_q[1:0]};
    assign arburst = AXI_BURST_INCR;
    assign rready  = rready_q;

    assign awvalid = awvalid_q;
    assign awaddr  = addr_q;
    assign awid    = ID_W'(LSU_ID);
    assign awlen   = 8'd0;
    assign awsize  = {1'b0, memop_q[1:0]};
    assign awburst = AXI_BURST_INCR;
    assign wvalid  = wvalid_q;
    assign wlast   = wvalid_q;
    assign bready  = bready_q;

    assign w_aw_fire = awvalid_q & awready;
    assign w_w_fire  = wvalid_q & wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            memop_q     <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            bready_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_rdata_q <= '0;
            out_exc_q   <= 1'b0;
            out_cause_q <= CAUSE_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        addr_q      <= in_addr;
                        wdata_q     <= in_wdata;
                        memop_q     <= in_memop;
                        out_rdata_q <= '0;
                        out_exc_q   <= 1'b0;
                        out_cause_q <= CAUSE_NONE;
                        if (in_memop == MEMOP_NONE) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                        end else if (is_misaligned(in_memop[1:0], in_addr[1:0])) begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            out_exc_q   <= 1'b1;
                            out_cause_q <= CAUSE_MISALIGN;
                        end else if (in_memwr) begin
                            state_q   <= S_WRITE;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done_q <= 1'b0;
                            w_done_q  <= 1'b0;
                        end else begin
                            state_q   <= S_ADDR_R;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                S_ADDR_R: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_DATA_R;
                    end
                end
                S_DATA_R: begin
                    if (rvalid && rlast) begin
                        rready_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                        if (rresp[1]) begin
                            out_exc_q   <= 1'b1;
                            out_cause_q <= CAUSE_FAULT;
                            out_rdata_q <= '0;
                        end else begin
                            out_rdata_q <= w_load;
                        end
                    end
                end
                S_WRITE: begin
                    // AW and W complete independently, in either order or together.
                    if (w_aw_fire) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_w_fire) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if ((aw_done_q || w_aw_fire) && (w_done_q || w_w_fire)) begin
                        bready_q <= 1'b1;
                        state_q  <= S_RESP_B;
                    end
                end
                S_RESP_B: begin
                    if (bvalid) begin
                        bready_q    <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                        if (bresp[1]) begin
                            out_exc_q   <= 1'b1;
                            out_cause_q <= CAUSE_FAULT;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060221_lsu_axi.sv
`default_nettype none
// ===========================================================================
// tb_ysyx_23060221_lsu_axi : directed-vector bench for the AXI load/store unit
// Revision: 1.0
// ===========================================================================
module tb_ysyx_23060221_lsu_axi;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // ---------------- 32-bit instance ----------------
    logic        in_valid = 0, in_memwr = 0, out_ready = 0;
    logic [31:0] in_addr = 0, in_wdata = 0;
    logic [2:0]  in_memop = 0;
    logic        in_ready, out_valid, out_exc;
    logic [31:0] out_rdata;
    logic [1:0]  out_cause;
    logic        awvalid, awready = 0, wvalid, wready = 0, wlast, bvalid = 0, bready;
    logic [31:0] awaddr, wdata, araddr;
    logic [3:0]  awid, wstrb, arid, bid = 0, rid = 0;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp = 0, rresp = 0;
    logic        arvalid, arready = 0, rvalid = 0, rready, rlast = 0;
    logic [31:0] rdata = 0;

    ysyx_23060221_lsu_axi #(.DATA_W(32), .ID_W(4), .LSU_ID(1)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_memop(in_memop), .in_memwr(in_memwr),
        .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
        .out_exc(out_exc), .out_cause(out_cause),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid), .awlen(awlen),
        .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid)
    );

    // ---------------- 64-bit instance ----------------
    logic        in_valid64 = 0, in_memwr64 = 0, out_ready64 = 0;
    logic [31:0] in_addr64 = 0, in_wdata64 = 0;
    logic [2:0]  in_memop64 = 0;
    logic        in_ready64, out_valid64, out_exc64;
    logic [31:0] out_rdata64;
    logic [1:0]  out_cause64;
    logic        awvalid64, awready64 = 0, wvalid64, wready64 = 0, wlast64, bvalid64 = 0, bready64;
    logic [31:0] awaddr64, araddr64;
    logic [63:0] wdata64;
    logic [7:0]  wstrb64, awlen64, arlen64;
    logic [3:0]  awid64, arid64, bid64 = 0, rid64 = 0;
    logic [2:0]  awsize64, arsize64;
    logic [1:0]  awburst64, arburst64, bresp64 = 0, rresp64 = 0;
    logic        arvalid64, arready64 = 0, rvalid64 = 0, rready64, rlast64 = 0;
    logic [63:0] rdata64 = 0;

    ysyx_23060221_lsu_axi #(.DATA_W(64), .ID_W(4), .LSU_ID(1)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_addr(in_addr64), .in_wdata(in_wdata64),
        .in_memop(in_memop64), .in_memwr(in_memwr64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_rdata(out_rdata64),
        .out_exc(out_exc64), .out_cause(out_cause64),
        .awvalid(awvalid64), .awready(awready64), .awaddr(awaddr64), .awid(awid64), .awlen(awlen64),
        .awsize(awsize64), .awburst(awburst64),
        .wvalid(wvalid64), .wready(wready64), .wdata(wdata64), .wstrb(wstrb64), .wlast(wlast64),
        .bvalid(bvalid64), .bready(bready64), .bresp(bresp64), .bid(bid64),
        .arvalid(arvalid64), .arready(arready64), .araddr(araddr64), .arid(arid64), .arlen(arlen64),
        .arsize(arsize64), .arburst(arburst64),
        .rvalid(rvalid64), .rready(rready64), .rdata(rdata64), .rresp(rresp64), .rlast(rlast64), .rid(rid64)
    );

    // Handshake and valid-cycle counters on the 32-bit bus.
    int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_r = 0, n_arv = 0, n_awv = 0, n_wv = 0;
    always @(posedge clk) begin
        if (arvalid && arready) n_ar++;
        if (awvalid && awready) n_aw++;
        if (wvalid && wready)   n_w++;
        if (bvalid && bready)   n_b++;
        if (rvalid && rready)   n_r++;
        if (arvalid) n_arv++;
        if (awvalid) n_awv++;
        if (wvalid)  n_wv++;
    end

    // Results of the last run_op.
    int          r_lat, t_bv, d_ar, d_b, d_arv, d_awv, d_wv;
    logic [31:0] r_rd, c_araddr, c_awaddr, c_wdata;
    logic        r_exc, c_wlast;
    logic [1:0]  r_cause, c_arburst;
    logic [2:0]  c_arsize, c_awsize;
    logic [7:0]  c_arlen;
    logic [3:0]  c_arid, c_wstrb;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and act as an AXI slave until out_valid (bounded).
    task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] mop,
                          input logic wr, input logic [31:0] rd, input logic [1:0] rr,
                          input logic [1:0] br, input int aw_dly);
        int ar0, aw0, w0, b0, r0, arv0, awv0, wv0;
        logic got_ar, got_aw, got_w;
        ar0 = n_ar; aw0 = n_aw; w0 = n_w; b0 = n_b; r0 = n_r; arv0 = n_arv; awv0 = n_awv; wv0 = n_wv;
        got_ar = 0; got_aw = 0; got_w = 0; t_bv = -1; r_lat = -1;
        in_addr = a; in_wdata = wd; in_memop = mop; in_memwr = wr; in_valid = 1; out_ready = 0;
        step();
        in_valid = 0;
        for (int c = 1; c <= 30; c++) begin
            if (out_valid) begin r_lat = c; break; end
            if (arvalid && !got_ar) begin
                got_ar = 1; c_araddr = araddr; c_arsize = arsize; c_arlen = arlen; c_arburst = arburst; c_arid = arid;
            end
            if (awvalid && !got_aw) begin got_aw = 1; c_awaddr = awaddr; c_awsize = awsize; end
            if (wvalid && !got_w) begin got_w = 1; c_wdata = wdata; c_wstrb = wstrb; c_wlast = wlast; end
            arready = 1;
            rvalid  = (n_ar > ar0) && (n_r == r0);
            rdata   = rd; rresp = rr; rlast = rvalid;
            awready = (c > aw_dly);
            wready  = 1;
            bvalid  = (n_aw > aw0) && (n_w > w0) && (n_b == b0);
            bresp   = br;
            if (bvalid && t_bv < 0) t_bv = c;
            step();
        end
        r_rd = out_rdata; r_exc = out_exc; r_cause = out_cause;
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        d_ar = n_ar - ar0; d_b = n_b - b0; d_arv = n_arv - arv0; d_awv = n_awv - awv0; d_wv = n_wv - wv0;
    endtask

    task automatic release_out();
        out_ready = 1;
        step();
        out_ready = 0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        nvec++; if ({out_valid, arvalid, awvalid, wvalid, rready, bready} !== 6'b0) begin nerr++;
            $display("FAIL reset_valids: got %b expected 000000", {out_valid, arvalid, awvalid, wvalid, rready, bready}); end
        nvec++; if ({out_rdata, out_exc, out_cause} !== 35'b0) begin nerr++;
            $display("FAIL reset_outputs: got rdata=%h exc=%b cause=%b expected 0", out_rdata, out_exc, out_cause); end
        nvec++; if ({in_ready64, out_valid64, arvalid64, awvalid64, wvalid64} !== 5'b10000) begin nerr++;
            $display("FAIL reset_dut64: got %b expected 10000", {in_ready64, out_valid64, arvalid64, awvalid64, wvalid64}); end
        rst = 1;
        step();
    endtask

    task automatic test_loads();
        logic [31:0] ta [0:5];
        logic [2:0]  tm [0:5];
        logic [31:0] te [0:5];
        logic [2:0]  ts [0:5];
        ta = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0002, 32'h8000_0000, 32'h8000_0001};
        tm = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        te = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_1234, 32'h0000_0012};
        ts = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0};
        for (int i = 0; i < 6; i++) begin
            run_op(ta[i], 32'h0, tm[i], 1'b0, 32'h80FF_1234, 2'b00, 2'b00, 0);
            nvec++; if (r_rd !== te[i]) begin nerr++; $display("FAIL load%0d_rdata: got %h expected %h", i, r_rd, te[i]); end
            nvec++; if ({r_exc, r_cause} !== 3'b000) begin nerr++; $display("FAIL load%0d_exc: got %b%b expected 000", i, r_exc, r_cause); end
            nvec++; if (r_lat !== 3) begin nerr++; $display("FAIL load%0d_latency: got %0d expected 3", i, r_lat); end
            nvec++; if (c_araddr !== ta[i] || c_arsize !== ts[i]) begin nerr++;
                $display("FAIL load%0d_ar: got addr=%h size=%0d expected addr=%h size=%0d", i, c_araddr, c_arsize, ta[i], ts[i]); end
            nvec++; if ({c_arlen, c_arburst, c_arid} !== {8'd0, 2'b01, 4'd1} || d_ar !== 1) begin nerr++;
                $display("FAIL load%0d_arfields: got len=%0d burst=%b id=%0d hs=%0d expected 0 01 1 1", i, c_arlen, c_arburst, c_arid, d_ar); end
            if (i == 0) begin
                repeat (2) step();
                nvec++; if (out_valid !== 1'b1 || out_rdata !== te[i]) begin nerr++;
                    $display("FAIL load_hold: got valid=%b rdata=%h expected 1 %h", out_valid, out_rdata, te[i]); end
            end
            release_out();
            nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++;
                $display("FAIL load%0d_release: got valid=%b ready=%b expected 0 1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_load_err_then_bypass();
        run_op(32'h8000_0000, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF, 2'b10, 2'b00, 0);
        nvec++; if ({r_exc, r_cause, r_rd} !== {1'b1, 2'b10, 32'h0}) begin nerr++;
            $display("FAIL rresp_err: got exc=%b cause=%b rdata=%h expected 1 10 0", r_exc, r_cause, r_rd); end
        nvec++; if (r_lat !== 3) begin nerr++; $display("FAIL rresp_err_latency: got %0d expected 3", r_lat); end
        release_out();
        run_op(32'h8000_0001, 32'h0, 3'b111, 1'b0, 32'h0, 2'b00, 2'b00, 0);
        nvec++; if ({r_exc, r_cause, r_rd} !== 35'b0) begin nerr++;
            $display("FAIL bypass_clear: got exc=%b cause=%b rdata=%h expected 0 00 0", r_exc, r_cause, r_rd); end
        nvec++; if (r_lat !== 1 || d_arv !== 0 || d_awv !== 0) begin nerr++;
            $display("FAIL bypass_timing: got lat=%0d arv=%0d awv=%0d expected 1 0 0", r_lat, d_arv, d_awv); end
        release_out();
    endtask

    task automatic test_misaligned();
        logic [31:0] ta [0:4];
        logic [2:0]  tm [0:4];
        logic        tw [0:4];
        ta = '{32'h8000_0002, 32'h8000_0001, 32'h8000_0003, 32'h8000_0001, 32'h8000_0003};
        tm = '{3'b010, 3'b001, 3'b101, 3'b010, 3'b001};
        tw = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], 32'h1234_5678, tm[i], tw[i], 32'h0, 2'b00, 2'b00, 0);
            nvec++; if ({r_exc, r_cause, r_rd} !== {1'b1, 2'b01, 32'h0}) begin nerr++;
                $display("FAIL misalign%0d_exc: got exc=%b cause=%b rdata=%h expected 1 01 0", i, r_exc, r_cause, r_rd); end
            nvec++; if (r_lat !== 1 || d_arv !== 0 || d_awv !== 0 || d_wv !== 0) begin nerr++;
                $display("FAIL misalign%0d_bus: got lat=%0d arv=%0d awv=%0d wv=%0d expected 1 0 0 0", i, r_lat, d_arv, d_awv, d_wv); end
            release_out();
        end
    endtask

    task automatic test_stores();
        logic [31:0] ta [0:2];
        logic [31:0] td [0:2];
        logic [2:0]  tm [0:2];
        logic [31:0] ew [0:2];
        logic [3:0]  es [0:2];
        ta = '{32'h8000_0001, 32'h8000_0002, 32'h8000_0004};
        td = '{32'h1234_5678, 32'h0000_ABCD, 32'hDEAD_BEEF};
        tm = '{3'b000, 3'b001, 3'b010};
        ew = '{32'h3456_7800, 32'hABCD_0000, 32'hDEAD_BEEF};
        es = '{4'b0010, 4'b1100, 4'b1111};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], td[i], tm[i], 1'b1, 32'h0, 2'b00, 2'b00, 0);
            nvec++; if (c_wdata !== ew[i] || c_wstrb !== es[i] || c_wlast !== 1'b1) begin nerr++;
                $display("FAIL store%0d_w: got data=%h strb=%b last=%b expected %h %b 1", i, c_wdata, c_wstrb, c_wlast, ew[i], es[i]); end
            nvec++; if (c_awaddr !== ta[i] || c_awsize !== {1'b0, tm[i][1:0]}) begin nerr++;
                $display("FAIL store%0d_aw: got addr=%h size=%0d expected %h %0d", i, c_awaddr, c_awsize, ta[i], tm[i][1:0]); end
            nvec++; if (r_lat !== 3 || d_b !== 1 || {r_exc, r_cause, r_rd} !== 35'b0) begin nerr++;
                $display("FAIL store%0d_result: got lat=%0d b=%0d exc=%b rdata=%h expected 3 1 0 0", i, r_lat, d_b, r_exc, r_rd); end
            release_out();
        end
        run_op(32'h8000_0010, 32'h1, 3'b010, 1'b1, 32'h0, 2'b00, 2'b10, 0);
        nvec++; if ({r_exc, r_cause} !== 3'b110 || r_lat !== 3) begin nerr++;
            $display("FAIL bresp_err: got exc=%b cause=%b lat=%0d expected 1 10 3", r_exc, r_cause, r_lat); end
        release_out();
    endtask

    task automatic test_store_aw_delay();
        run_op(32'h8000_0008, 32'hCAFE_F00D, 3'b010, 1'b1, 32'h0, 2'b00, 2'b00, 3);
        nvec++; if (d_awv !== 4 || d_wv !== 1) begin nerr++;
            $display("FAIL awdelay_valids: got awv=%0d wv=%0d expected 4 1", d_awv, d_wv); end
        nvec++; if (d_b !== 1) begin nerr++; $display("FAIL awdelay_bcount: got %0d expected 1", d_b); end
        nvec++; if (t_bv !== 5 || r_lat !== 6) begin nerr++;
            $display("FAIL awdelay_timing: got bvalid@%0d out_valid@%0d expected 5 6", t_bv, r_lat); end
        release_out();
    endtask

    task automatic test_dut64();
        in_addr64 = 32'h8000_0006; in_wdata64 = 32'h0000_ABCD; in_memop64 = 3'b001; in_memwr64 = 1; in_valid64 = 1;
        step();
        in_valid64 = 0;
        nvec++; if (wdata64 !== 64'hABCD_0000_0000_0000 || wstrb64 !== 8'hC0) begin nerr++;
            $display("FAIL sh64_w: got data=%h strb=%h expected abcd000000000000 c0", wdata64, wstrb64); end
        nvec++; if ({awvalid64, wvalid64, wlast64, awsize64} !== {3'b111, 3'd1} || awaddr64 !== 32'h8000_0006) begin nerr++;
            $display("FAIL sh64_aw: got aw=%b w=%b last=%b size=%0d addr=%h expected 1 1 1 1 80000006",
                     awvalid64, wvalid64, wlast64, awsize64, awaddr64); end
        awready64 = 1; wready64 = 1;
        step();
        awready64 = 0; wready64 = 0; bvalid64 = 1;
        step();
        bvalid64 = 0;
        nvec++; if (out_valid64 !== 1'b1 || out_exc64 !== 1'b0) begin nerr++;
            $display("FAIL sh64_done: got valid=%b exc=%b expected 1 0", out_valid64, out_exc64); end
        out_ready64 = 1;
        step();
        out_ready64 = 0;
        in_addr64 = 32'h8000_0005; in_memop64 = 3'b100; in_memwr64 = 0; in_valid64 = 1;
        step();
        in_valid64 = 0; arready64 = 1;
        step();
        arready64 = 0; rvalid64 = 1; rlast64 = 1; rdata64 = 64'h0000_AA00_0000_0000;
        step();
        rvalid64 = 0; rlast64 = 0;
        nvec++; if (out_valid64 !== 1'b1 || out_rdata64 !== 32'h0000_00AA) begin nerr++;
            $display("FAIL lbu64: got valid=%b rdata=%h expected 1 000000aa", out_valid64, out_rdata64); end
        out_ready64 = 1;
        step();
        out_ready64 = 0;
    endtask

    task automatic test_back_to_back();
        run_op(32'h8000_0000, 32'h0, 3'b111, 1'b0, 32'h0, 2'b00, 2'b00, 0);
        in_memop = 3'b111; in_valid = 1; out_ready = 1;
        step();
        out_ready = 0;
        nvec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin nerr++;
            $display("FAIL b2b_gap: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
        step();
        in_valid = 0;
        nvec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin nerr++;
            $display("FAIL b2b_second: got valid=%b ready=%b expected 1 0", out_valid, in_ready); end
        release_out();
    endtask

    task automatic test_async_reset();
        in_addr = 32'h8000_0000; in_memop = 3'b010; in_memwr = 0; in_valid = 1; arready = 1;
        step();
        in_valid = 0;
        step();
        arready = 0;
        nvec++; if (rready !== 1'b1) begin nerr++; $display("FAIL areset_pre: got rready=%b expected 1", rready); end
        #2 rst = 0;
        #1;
        nvec++; if ({out_valid, arvalid, awvalid, wvalid, rready, bready, in_ready} !== 7'b0000001) begin nerr++;
            $display("FAIL areset_async: got %b expected 0000001", {out_valid, arvalid, awvalid, wvalid, rready, bready, in_ready}); end
        @(negedge clk);
        rst = 1;
        step();
        nvec++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || rready !== 1'b0) begin nerr++;
            $display("FAIL areset_release: got ready=%b valid=%b rready=%b expected 1 0 0", in_ready, out_valid, rready); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_loads();
        test_load_err_then_bypass();
        test_misaligned();
        test_stores();
        test_store_aw_delay();
        test_dut64();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
